misc_share_ctrl: RTL and testbench
==================================

Name: misc_share_ctrl

Overview:
- Round-robin scheduler that shares one Misc arithmetic datapath among NREQ requesters.
- Misc takes 8-bit A, B, C and returns XOUT1 and XOUT2, where XOUT2 = A - B + C + 5 mod 2^W.
- This block accepts requests over valid/ready, drives the shared unit's operands, and waits a configurable unit latency.
- It captures both results and returns them with the requester ID over a valid/ready response channel.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand/result width; matches the Misc datapath width.
- LATENCY, 0, cycles from operand change to valid result at the shared unit (0 = combinational Misc).
- IDW, 2, requester ID width, $clog2(NREQ).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  NREQ  per-requester request valid.
- REQ_READY  out  NREQ  per-requester accept; at most one bit high.
- REQ_A  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- REQ_B  in  NREQ*W  operand B, same packing.
- REQ_C  in  NREQ*W  operand C, same packing.
- M_A  out  W  operand A to shared Misc unit.
- M_B  out  W  operand B to shared Misc unit.
- M_C  out  W  operand C to shared Misc unit.
- M_X1  in  W  XOUT1 from shared unit.
- M_X2  in  W  XOUT2 from shared unit.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response consumer ready.
- RSP_ID  out  IDW  index of the requester that owns the response.
- RSP_X1  out  W  captured XOUT1.
- RSP_X2  out  W  captured XOUT2.
- OP_COUNT  out  16  completed responses, wraps modulo 2^16.
- BUSY  out  1  high in EXEC or RESP.

Behaviour:
- Reset (RST_N low, asynchronous) clears all state and outputs immediately:
  - state = IDLE; REQ_READY = 0; RSP_VALID = 0; BUSY = 0.
  - RSP_ID/RSP_X1/RSP_X2 = 0; M_A/M_B/M_C = 0; OP_COUNT = 0.
  - rr_ptr = NREQ-1, so requester 0 has first priority.
- A reset asserted mid-operation abandons the operation. No response is emitted for it. The requester's handshake has already completed and is not repeated.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g = first i with REQ_VALID[i] set, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - REQ_READY[g] is combinational: high in the same cycle, only in IDLE.
  - On the handshake, register operand slice g into M_A/M_B/M_C and g into RSP_ID; set rr_ptr = g; set cnt = LATENCY; go to EXEC.
  - With no REQ_VALID bit set, stay in IDLE.
- EXEC:
  - M_A/M_B/M_C are held stable.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, capture M_X1 into RSP_X1 and M_X2 into RSP_X2, then go to RESP.
  - EXEC therefore lasts LATENCY+1 cycles. Inputs REQ_* are ignored and REQ_READY = 0.
- RESP:
  - RSP_VALID = 1; RSP_ID/RSP_X1/RSP_X2 are stable until the handshake.
  - On RSP_VALID and RSP_READY: increment OP_COUNT and go to IDLE.
  - Backpressure holds RESP indefinitely.
- Timing with handshake at cycle t:
  - EXEC runs t+1 .. t+1+LATENCY.
  - RSP_VALID rises at t+2+LATENCY.
  - With RSP_READY already high, the next grant can occur at t+3+LATENCY.
  - Peak throughput is one operation per LATENCY+3 cycles.
- M_A/M_B/M_C keep their last operands outside EXEC; they do not return to zero.
- A requester may drop REQ_VALID before it is granted; no grant results.
- All requesters valid continuously: grant order 0,1,2,3,0,... with no starvation.
- Width rule: W-bit modular wrap throughout; the block performs no arithmetic on operands.

Decomposition:
- Shared package misc_pkg holds:
  - the FSM state enum typedef (IDLE/EXEC/RESP);
  - a W-parameterised operand struct packed {a, b, c} via macro, since hierarchical typedefs are not relied on;
  - constant MISC_W = 8.
- One natural sub-module, rr_arbiter: NREQ-wide round-robin priority select.
  - Inputs: REQ_VALID, rr_ptr.
  - Outputs: one-hot grant and grant index.
- The Misc unit stays outside; the bench instantiates it and connects M_* to it.

Test Plan:
- Single request, LATENCY=0: requester 2 sends A=10, B=3, C=4 → REQ_READY[2] in the same cycle; RSP_VALID two cycles later with RSP_ID=2, RSP_X2=16, RSP_X1 matching the Misc model; OP_COUNT=1.
- Wrap-around: A=0, B=1, C=0 → RSP_X2=4; A=255, B=0, C=255 → RSP_X2=3 (mod 256).
- All four valid continuously with RSP_READY=1 → grants 0,1,2,3,0 on cycles t, t+3, t+6, t+9, t+12; no REQ_READY during EXEC/RESP.
- Backpressure: RSP_READY low for 5 cycles in RESP → RSP_* held constant, no new grant; release → IDLE next cycle.
- LATENCY=3 with a registered Misc model: response at t+5; captured values equal the model, never stale.
- Reset mid-EXEC: RST_N low asynchronously → RSP_VALID=0 and BUSY=0 immediately, OP_COUNT=0; after release, requester 0 wins over 3 when both are valid.

Source files
------------

// File: rtl/misc_pkg.sv
// misc_pkg: shared types for the Misc datapath scheduler.
// State encoding, operand bundle and datapath width.
`ifndef MISC_OPERAND_T
`define MISC_OPERAND_T(WID) struct packed { logic [(WID)-1:0] a; logic [(WID)-1:0] b; logic [(WID)-1:0] c; }
`endif

package misc_pkg;

    localparam int MISC_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/misc_share_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin priority select.
// Searches from rr_ptr+1 upward, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    // Walk from the farthest slot back to the nearest so the nearest wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[IDW'(idx)]) begin
                grant              = '0;
                grant[IDW'(idx)]   = 1'b1;
                grant_idx          = IDW'(idx);
                grant_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/misc_share_ctrl.sv
// misc_share_ctrl: shares one Misc datapath among NREQ requesters.
// Grants round-robin, waits LATENCY cycles, returns both results.
module misc_share_ctrl
    import misc_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = MISC_W,
    parameter int LATENCY = 0,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [NREQ*W-1:0] REQ_A,
    input  logic [NREQ*W-1:0] REQ_B,
    input  logic [NREQ*W-1:0] REQ_C,
    output logic [W-1:0]      M_A,
    output logic [W-1:0]      M_B,
    output logic [W-1:0]      M_C,
    input  logic [W-1:0]      M_X1,
    input  logic [W-1:0]      M_X2,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [IDW-1:0]    RSP_ID,
    output logic [W-1:0]      RSP_X1,
    output logic [W-1:0]      RSP_X2,
    output logic [15:0]       OP_COUNT,
    output logic              BUSY
);

    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef `MISC_OPERAND_T(W) operand_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    operand_t        ops_q, ops_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [W-1:0]    x1_q, x1_d;
    logic [W-1:0]    x2_q, x2_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [15:0]     nops_q, nops_d;
    logic [NREQ-1:0] ready_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;

    logic [W-1:0]    a_arr [NREQ];
    logic [W-1:0]    b_arr [NREQ];
    logic [W-1:0]    c_arr [NREQ];

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_valid (REQ_VALID),
        .rr_ptr    (ptr_q),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    // Unpack the flat operand buses into per-requester slots.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = REQ_A[i*W +: W];
            b_arr[i] = REQ_B[i*W +: W];
            c_arr[i] = REQ_C[i*W +: W];
        end
    end

    // Next-state and datapath update for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ops_d   = ops_q;
        id_d    = id_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        ptr_d   = ptr_q;
        nops_d  = nops_q;
        ready_d = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    ready_d = gnt;
                    ops_d.a = a_arr[gnt_idx];
                    ops_d.b = b_arr[gnt_idx];
                    ops_d.c = c_arr[gnt_idx];
                    id_d    = gnt_idx;
                    ptr_d   = gnt_idx;
                    cnt_d   = CW'(LATENCY);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    x1_d    = M_X1;
                    x2_d    = M_X2;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    nops_d  = nops_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset hands requester 0 first priority.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ops_q   <= '0;
            id_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            ptr_q   <= IDW'(NREQ - 1);
            nops_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ops_q   <= ops_d;
            id_q    <= id_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            ptr_q   <= ptr_d;
            nops_q  <= nops_d;
        end
    end

    assign REQ_READY = ready_d & {NREQ{RST_N}};
    assign M_A       = ops_q.a;
    assign M_B       = ops_q.b;
    assign M_C       = ops_q.c;
    assign RSP_VALID = (state_q == RESP);
    assign RSP_ID    = id_q;
    assign RSP_X1    = x1_q;
    assign RSP_X2    = x2_q;
    assign OP_COUNT  = nops_q;
    assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_misc_share_ctrl.sv
// tb_misc_share_ctrl: scoreboard bench for the shared Misc scheduler.
// Two instances: combinational unit (LATENCY=0) and 3-stage unit.
module tb_misc_share_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   x1;
        logic [W-1:0]   x2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_ops0 = 0;
    exp_t q0[$];
    exp_t q3[$];

    function automatic logic [W-1:0] mx1(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        return (a ^ b) + c;
    endfunction

    function automatic logic [W-1:0] mx2(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        return a - b + c + 8'd5;
    endfunction

    logic [NREQ-1:0]   req_valid0, req_ready0;
    logic [NREQ*W-1:0] req_a0, req_b0, req_c0;
    logic [W-1:0]      m_a0, m_b0, m_c0, m_x1_0, m_x2_0;
    logic              rsp_valid0, rsp_ready0, busy0;
    logic [IDW-1:0]    rsp_id0;
    logic [W-1:0]      rsp_x1_0, rsp_x2_0;
    logic [15:0]       op_count0;

    logic [NREQ-1:0]   req_valid3, req_ready3;
    logic [NREQ*W-1:0] req_a3, req_b3, req_c3;
    logic [W-1:0]      m_a3, m_b3, m_c3, m_x1_3, m_x2_3;
    logic              rsp_valid3, rsp_ready3, busy3;
    logic [IDW-1:0]    rsp_id3;
    logic [W-1:0]      rsp_x1_3, rsp_x2_3;
    logic [15:0]       op_count3;

    logic [W-1:0] p1x1, p2x1, p3x1, p1x2, p2x2, p3x2;

    assign m_x1_0 = mx1(m_a0, m_b0, m_c0);
    assign m_x2_0 = mx2(m_a0, m_b0, m_c0);

    // Registered Misc model: three pipeline stages.
    always @(posedge clk) begin
        p1x1 <= mx1(m_a3, m_b3, m_c3);
        p1x2 <= mx2(m_a3, m_b3, m_c3);
        p2x1 <= p1x1;
        p2x2 <= p1x2;
        p3x1 <= p2x1;
        p3x2 <= p2x2;
    end
    assign m_x1_3 = p3x1;
    assign m_x2_3 = p3x2;

    misc_share_ctrl #(.NREQ(NREQ), .W(W), .LATENCY(0), .IDW(IDW)) dut0 (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid0), .REQ_READY(req_ready0),
        .REQ_A(req_a0), .REQ_B(req_b0), .REQ_C(req_c0),
        .M_A(m_a0), .M_B(m_b0), .M_C(m_c0),
        .M_X1(m_x1_0), .M_X2(m_x2_0),
        .RSP_VALID(rsp_valid0), .RSP_READY(rsp_ready0),
        .RSP_ID(rsp_id0), .RSP_X1(rsp_x1_0), .RSP_X2(rsp_x2_0),
        .OP_COUNT(op_count0), .BUSY(busy0)
    );

    misc_share_ctrl #(.NREQ(NREQ), .W(W), .LATENCY(3), .IDW(IDW)) dut3 (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid3), .REQ_READY(req_ready3),
        .REQ_A(req_a3), .REQ_B(req_b3), .REQ_C(req_c3),
        .M_A(m_a3), .M_B(m_b3), .M_C(m_c3),
        .M_X1(m_x1_3), .M_X2(m_x2_3),
        .RSP_VALID(rsp_valid3), .RSP_READY(rsp_ready3),
        .RSP_ID(rsp_id3), .RSP_X1(rsp_x1_3), .RSP_X2(rsp_x2_3),
        .OP_COUNT(op_count3), .BUSY(busy3)
    );

    // Response monitor for the combinational instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid0 && rsp_ready0) begin
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL rsp0_unexpected: got id=%0d x1=%0d x2=%0d, required no response",
                         rsp_id0, rsp_x1_0, rsp_x2_0);
            end else begin
                e = q0.pop_front();
                if ({rsp_id0, rsp_x1_0, rsp_x2_0} !== e) begin
                    fails++;
                    $display("FAIL rsp0_data: got id=%0d x1=%0d x2=%0d, required id=%0d x1=%0d x2=%0d",
                             rsp_id0, rsp_x1_0, rsp_x2_0, e.id, e.x1, e.x2);
                end
            end
        end
    end

    // Response monitor for the pipelined instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid3 && rsp_ready3) begin
            tests++;
            if (q3.size() == 0) begin
                fails++;
                $display("FAIL rsp3_unexpected: got id=%0d x1=%0d x2=%0d, required no response",
                         rsp_id3, rsp_x1_3, rsp_x2_3);
            end else begin
                e = q3.pop_front();
                if ({rsp_id3, rsp_x1_3, rsp_x2_3} !== e) begin
                    fails++;
                    $display("FAIL rsp3_data: got id=%0d x1=%0d x2=%0d, required id=%0d x1=%0d x2=%0d",
                             rsp_id3, rsp_x1_3, rsp_x2_3, e.id, e.x1, e.x2);
                end
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid0 = 4'hF;
        req_valid3 = 4'hF;
        @(negedge clk);
        tests++;
        if (req_ready0 !== 4'h0) begin
            fails++;
            $display("FAIL reset_ready: got %b, required 0000", req_ready0);
        end
        tests++;
        if ({rsp_valid0, busy0} !== 2'b00) begin
            fails++;
            $display("FAIL reset_valid_busy: got %b, required 00", {rsp_valid0, busy0});
        end
        tests++;
        if (op_count0 !== 16'd0) begin
            fails++;
            $display("FAIL reset_opcount: got %0d, required 0", op_count0);
        end
        tests++;
        if ({m_a0, m_b0, m_c0, rsp_id0, rsp_x1_0, rsp_x2_0} !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h, required 0",
                     {m_a0, m_b0, m_c0, rsp_id0, rsp_x1_0, rsp_x2_0});
        end
        tests++;
        if (req_ready3 !== 4'h0) begin
            fails++;
            $display("FAIL reset_ready3: got %b, required 0000", req_ready3);
        end
        @(posedge clk);
        #1;
        req_valid0 = 4'h0;
        req_valid3 = 4'h0;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        int exp_g;
        exp_g = 0;
        for (int c = 0; c < 15; c++) begin
            logic [NREQ-1:0] er;
            logic eb;
            @(posedge clk);
            #1;
            req_valid0 = (c < 13) ? 4'hF : 4'h0;
            @(negedge clk);
            er = (c <= 12 && c % 3 == 0) ? 4'(1 << exp_g) : 4'h0;
            eb = (c > 12) || (c % 3 != 0);
            tests++;
            if (req_ready0 !== er) begin
                fails++;
                $display("FAIL rr_ready c=%0d: got %b, required %b", c, req_ready0, er);
            end
            tests++;
            if (busy0 !== eb) begin
                fails++;
                $display("FAIL rr_busy c=%0d: got %b, required %b", c, busy0, eb);
            end
            if (er != 4'h0) begin
                q0.push_back(exp_t'{id: IDW'(exp_g),
                    x1: mx1(req_a0[exp_g*W +: W], req_b0[exp_g*W +: W], req_c0[exp_g*W +: W]),
                    x2: mx2(req_a0[exp_g*W +: W], req_b0[exp_g*W +: W], req_c0[exp_g*W +: W])});
                exp_g = (exp_g + 1) % NREQ;
                exp_ops0++;
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (op_count0 !== 16'(exp_ops0)) begin
            fails++;
            $display("FAIL rr_opcount: got %0d, required %0d", op_count0, exp_ops0);
        end
    endtask

    task automatic test_single;
        @(posedge clk);
        #1;
        req_a0[2*W +: W] = 8'd10;
        req_b0[2*W +: W] = 8'd3;
        req_c0[2*W +: W] = 8'd4;
        req_valid0 = 4'b0100;
        @(negedge clk);
        tests++;
        if (req_ready0 !== 4'b0100) begin
            fails++;
            $display("FAIL single_ready: got %b, required 0100", req_ready0);
        end
        q0.push_back(exp_t'{id: 2'd2, x1: mx1(8'd10, 8'd3, 8'd4), x2: 8'd16});
        @(posedge clk);
        #1;
        req_valid0 = 4'h0;
        @(negedge clk);
        tests++;
        if ({busy0, rsp_valid0} !== 2'b10) begin
            fails++;
            $display("FAIL single_exec: got busy,valid=%b, required 10", {busy0, rsp_valid0});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (rsp_valid0 !== 1'b1) begin
            fails++;
            $display("FAIL single_rsp_valid: got %b, required 1", rsp_valid0);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        exp_ops0++;
        tests++;
        if (op_count0 !== 16'(exp_ops0)) begin
            fails++;
            $display("FAIL single_opcount: got %0d, required %0d", op_count0, exp_ops0);
        end
    endtask

    task automatic test_wrap;
        logic [W-1:0] ta [2];
        logic [W-1:0] tb [2];
        logic [W-1:0] tc [2];
        logic [W-1:0] tx [2];
        ta[0] = 8'd0;   tb[0] = 8'd1; tc[0] = 8'd0;   tx[0] = 8'd4;
        ta[1] = 8'd255; tb[1] = 8'd0; tc[1] = 8'd255; tx[1] = 8'd3;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk);
            #1;
            req_a0[1*W +: W] = ta[j];
            req_b0[1*W +: W] = tb[j];
            req_c0[1*W +: W] = tc[j];
            req_valid0 = 4'b0010;
            @(negedge clk);
            tests++;
            if (req_ready0 !== 4'b0010) begin
                fails++;
                $display("FAIL wrap_ready j=%0d: got %b, required 0010", j, req_ready0);
            end
            q0.push_back(exp_t'{id: 2'd1, x1: mx1(ta[j], tb[j], tc[j]), x2: tx[j]});
            exp_ops0++;
            @(posedge clk);
            #1;
            req_valid0 = 4'h0;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (op_count0 !== 16'(exp_ops0)) begin
            fails++;
            $display("FAIL wrap_opcount: got %0d, required %0d", op_count0, exp_ops0);
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] ex2;
        ex2 = mx2(req_a0[3*W +: W], req_b0[3*W +: W], req_c0[3*W +: W]);
        @(posedge clk);
        #1;
        rsp_ready0 = 1'b0;
        req_valid0 = 4'b1011;
        @(negedge clk);
        tests++;
        if (req_ready0 !== 4'b1000) begin
            fails++;
            $display("FAIL bp_grant: got %b, required 1000", req_ready0);
        end
        q0.push_back(exp_t'{id: 2'd3,
            x1: mx1(req_a0[3*W +: W], req_b0[3*W +: W], req_c0[3*W +: W]), x2: ex2});
        exp_ops0++;
        @(posedge clk);
        #1;
        req_valid0 = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            tests++;
            if ({rsp_valid0, req_ready0, rsp_id0, rsp_x2_0} !== {1'b1, 4'h0, 2'd3, ex2}) begin
                fails++;
                $display("FAIL bp_hold k=%0d: got v=%b rdy=%b id=%0d x2=%0d, required v=1 rdy=0000 id=3 x2=%0d",
                         k, rsp_valid0, req_ready0, rsp_id0, rsp_x2_0, ex2);
            end
        end
        @(posedge clk);
        #1;
        rsp_ready0 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if ({busy0, req_ready0} !== {1'b0, 4'b0001}) begin
            fails++;
            $display("FAIL bp_release: got busy=%b rdy=%b, required busy=0 rdy=0001", busy0, req_ready0);
        end
        q0.push_back(exp_t'{id: 2'd0,
            x1: mx1(req_a0[0 +: W], req_b0[0 +: W], req_c0[0 +: W]),
            x2: mx2(req_a0[0 +: W], req_b0[0 +: W], req_c0[0 +: W])});
        exp_ops0++;
        @(posedge clk);
        #1;
        req_valid0 = 4'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (op_count0 !== 16'(exp_ops0)) begin
            fails++;
            $display("FAIL bp_opcount: got %0d, required %0d", op_count0, exp_ops0);
        end
    endtask

    task automatic test_latency3;
        logic [W-1:0] ta [2];
        logic [W-1:0] tb [2];
        logic [W-1:0] tc [2];
        int           tid [2];
        ta[0] = 8'd11;  tb[0] = 8'd22;  tc[0] = 8'd33; tid[0] = 1;
        ta[1] = 8'd200; tb[1] = 8'd100; tc[1] = 8'd77; tid[1] = 2;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk);
            #1;
            req_a3[tid[j]*W +: W] = ta[j];
            req_b3[tid[j]*W +: W] = tb[j];
            req_c3[tid[j]*W +: W] = tc[j];
            req_valid3 = 4'(1 << tid[j]);
            @(negedge clk);
            tests++;
            if (req_ready3 !== 4'(1 << tid[j])) begin
                fails++;
                $display("FAIL lat3_ready j=%0d: got %b, required %b", j, req_ready3, 4'(1 << tid[j]));
            end
            q3.push_back(exp_t'{id: IDW'(tid[j]),
                x1: mx1(ta[j], tb[j], tc[j]), x2: mx2(ta[j], tb[j], tc[j])});
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk);
                #1;
                req_valid3 = 4'h0;
                @(negedge clk);
                tests++;
                if ({busy3, rsp_valid3} !== 2'b10) begin
                    fails++;
                    $display("FAIL lat3_exec j=%0d t+%0d: got busy,valid=%b, required 10",
                             j, k, {busy3, rsp_valid3});
                end
            end
            @(posedge clk);
            #1;
            @(negedge clk);
            tests++;
            if (rsp_valid3 !== 1'b1) begin
                fails++;
                $display("FAIL lat3_rsp j=%0d: got valid=%b at t+5, required 1", j, rsp_valid3);
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (op_count3 !== 16'd2) begin
            fails++;
            $display("FAIL lat3_opcount: got %0d, required 2", op_count3);
        end
    endtask

    task automatic test_reset_mid_exec;
        @(posedge clk);
        #1;
        req_valid0 = 4'b0010;
        @(negedge clk);
        tests++;
        if (req_ready0 !== 4'b0010) begin
            fails++;
            $display("FAIL rst_mid_grant: got %b, required 0010", req_ready0);
        end
        @(posedge clk);
        #1;
        req_valid0 = 4'h0;
        @(negedge clk);
        tests++;
        if (busy0 !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_exec: got busy=%b, required 1", busy0);
        end
        #1;
        rst_n = 1'b0;
        #1;
        exp_ops0 = 0;
        tests++;
        if ({rsp_valid0, busy0, op_count0} !== {1'b0, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL rst_mid_async: got valid=%b busy=%b count=%0d, required 0 0 0",
                     rsp_valid0, busy0, op_count0);
        end
        req_valid0 = 4'b1001;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (req_ready0 !== 4'b0001) begin
            fails++;
            $display("FAIL rst_mid_priority: got %b, required 0001", req_ready0);
        end
        q0.push_back(exp_t'{id: 2'd0,
            x1: mx1(req_a0[0 +: W], req_b0[0 +: W], req_c0[0 +: W]),
            x2: mx2(req_a0[0 +: W], req_b0[0 +: W], req_c0[0 +: W])});
        exp_ops0++;
        @(posedge clk);
        #1;
        req_valid0 = 4'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (op_count0 !== 16'(exp_ops0)) begin
            fails++;
            $display("FAIL rst_mid_opcount: got %0d, required %0d", op_count0, exp_ops0);
        end
    endtask

    initial begin
        req_valid0 = '0;
        req_valid3 = '0;
        rsp_ready0 = 1'b1;
        rsp_ready3 = 1'b1;
        req_a3 = '0;
        req_b3 = '0;
        req_c3 = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a0[i*W +: W] = W'(40 * i + 7);
            req_b0[i*W +: W] = W'(3 * i + 1);
            req_c0[i*W +: W] = W'(i + 100);
        end

        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_backpressure();
        test_latency3();
        test_reset_mid_exec();

        tests++;
        if (q0.size() != 0 || q3.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", q0.size(), q3.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
